// File: rtl/move_ctrl_pkg.sv
// Shared types and widths for the move controller.
package move_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  localparam int TIMER_MIN_W = 10;
  localparam int COUNT_W     = 14;

  // Timer is at least 10 bits, wider if the timeout needs it.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > TIMER_MIN_W) ? w : TIMER_MIN_W;
  endfunction

endpackage

// File: rtl/move_timer.sv
// WAIT_DONE timeout timer: down-counter of remaining wait cycles,
// loaded on start, expired at terminal count zero.
module move_timer
  import move_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int W       = timer_width(TIMEOUT)
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  output logic expired
);

  logic [W-1:0] r_remain;

  // Load TIMEOUT-1 on entry so the TIMEOUT-th wait edge sees zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_remain <= '0;
    end else if (start) begin
      r_remain <= W'(TIMEOUT - 1);
    end else if (r_remain != '0) begin
      r_remain <= r_remain - 1'b1;
    end
  end

  assign expired = (r_remain == '0);

endmodule

// File: rtl/move_controller.sv
// Move request controller: turns direction buttons into one move per press,
// handshakes with the datapath and guards the wait for move_done.
// Optional macro MOVE_LIMIT_EN adds a saturating move cap (MAX_MOVES).
//
// state     | meaning
// IDLE      | waiting for a press while not blocked
// REQ       | move_req high until the datapath takes it
// WAIT_DONE | waiting for move_done, bounded by the timer
// RELEASE   | waiting for all buttons up
module move_controller
  import move_ctrl_pkg::*;
#(
  parameter int DONE_TIMEOUT = 1023,
  parameter int MAX_MOVES    = 9999
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       game_over,
  input  logic       bn,
  input  logic       be,
  input  logic       bs,
  input  logic       bw,
  input  logic       move_ready,
  input  logic       move_done,
  output logic       move_req,
  output logic [1:0] move_dir,
  output logic       count_inc,
  output logic       busy,
  output logic       timeout_err,
  output logic       limit_hit
);

  state_t r_state, w_state_next;
  dir_t   r_move_dir, w_dir_next, w_enc;
  logic   r_move_req, w_req_next;
  logic   r_count_inc, r_busy, r_timeout_err;
  logic   w_any, w_block, w_limit;
  logic   w_timer_start, w_expired, w_done_hit, w_timeout_hit;

  assign w_any   = bn | be | bs | bw;
  assign w_block = game_over | w_limit;

  // Fixed-priority direction encode, N highest.
  always_comb begin
    w_enc = DIR_W;
    if (bn)      w_enc = DIR_N;
    else if (be) w_enc = DIR_E;
    else if (bs) w_enc = DIR_S;
  end

  move_timer #(
    .TIMEOUT(DONE_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .clr    (clr),
    .start  (w_timer_start),
    .expired(w_expired)
  );

  // Next state and next registered output values.
  always_comb begin
    w_state_next  = r_state;
    w_req_next    = r_move_req;
    w_dir_next    = r_move_dir;
    w_timer_start = 1'b0;
    w_done_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_block && w_any) begin
          w_state_next = REQ;
          w_req_next   = 1'b1;
          w_dir_next   = w_enc;
        end
      end
      REQ: begin
        if (move_ready) begin
          w_state_next  = WAIT_DONE;
          w_req_next    = 1'b0;
          w_timer_start = 1'b1;
        end else if (game_over) begin
          w_state_next = RELEASE;
          w_req_next   = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (move_done) begin
          w_state_next = RELEASE;
          w_done_hit   = 1'b1;
        end else if (w_expired) begin
          w_state_next  = RELEASE;
          w_timeout_hit = 1'b1;
        end
      end
      RELEASE: begin
        if (!w_any) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= IDLE;
      r_move_req    <= 1'b0;
      r_move_dir    <= DIR_N;
      r_count_inc   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_move_req  <= w_req_next;
      r_move_dir  <= w_dir_next;
      r_count_inc <= w_done_hit;
      r_busy      <= (w_state_next != IDLE);
      if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

`ifdef MOVE_LIMIT_EN
  logic [COUNT_W-1:0] r_move_cnt;
  logic               r_limit_hit;

  // Saturating count of completed moves; limit flags once the cap is reached.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_move_cnt  <= '0;
      r_limit_hit <= 1'b0;
    end else if (w_done_hit && (r_move_cnt != COUNT_W'(MAX_MOVES))) begin
      r_move_cnt  <= r_move_cnt + 1'b1;
      r_limit_hit <= ((r_move_cnt + 1'b1) == COUNT_W'(MAX_MOVES));
    end
  end

  assign w_limit = r_limit_hit;
`else
  logic w_unused_max_moves;
  assign w_unused_max_moves = (MAX_MOVES != 0);
  assign w_limit            = 1'b0;
`endif

  assign move_req    = r_move_req;
  assign move_dir    = r_move_dir;
  assign count_inc   = r_count_inc;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign limit_hit   = w_limit;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller (DONE_TIMEOUT=8, MAX_MOVES=3).
module tb_move_controller;

  logic       clk = 1'b0;
  logic       clr, game_over, bn, be, bs, bw, move_ready, move_done;
  logic       move_req, count_inc, busy, timeout_err, limit_hit;
  logic [1:0] move_dir;

  int n_cmp = 0;
  int n_err = 0;
  int n_inc = 0;
  int base;

  always #5 clk = ~clk;

  move_controller #(
    .DONE_TIMEOUT(8),
    .MAX_MOVES   (3)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .game_over  (game_over),
    .bn         (bn),
    .be         (be),
    .bs         (bs),
    .bw         (bw),
    .move_ready (move_ready),
    .move_done  (move_done),
    .move_req   (move_req),
    .move_dir   (move_dir),
    .count_inc  (count_inc),
    .busy       (busy),
    .timeout_err(timeout_err),
    .limit_hit  (limit_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle; tallies count_inc pulses seen.
  task automatic step();
    @(posedge clk);
    #1;
    if (count_inc === 1'b1) n_inc++;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    {bn, be, bs, bw} = 4'b0000;
    move_ready = 1'b0;
    move_done  = 1'b0;
    game_over  = 1'b0;
    step();
    clr = 1'b0;
  endtask

  // {bn,be,bs,bw} patterns and the expected resolved direction.
  logic [3:0] pat_btn [6] = '{4'b1010, 4'b0101, 4'b1111, 4'b0011, 4'b0001, 4'b0110};
  logic [1:0] pat_dir [6] = '{2'b00,   2'b01,   2'b00,   2'b10,   2'b11,   2'b01};

  initial begin
    clr = 1'b1; game_over = 1'b0;
    {bn, be, bs, bw} = 4'b0000;
    move_ready = 1'b0; move_done = 1'b0;
    step(); step();
    check("rst_req",   move_req,    0);
    check("rst_dir",   move_dir,    0);
    check("rst_inc",   count_inc,   0);
    check("rst_busy",  busy,        0);
    check("rst_terr",  timeout_err, 0);
    check("rst_limit", limit_hit,   0);
    clr = 1'b0;

`ifdef MOVE_LIMIT_EN
    for (int m = 0; m < 3; m++) begin
      check("lim_before", limit_hit, 0);
      bn = 1'b1; move_ready = 1'b1;
      step(); step();
      move_ready = 1'b0; move_done = 1'b1;
      step();
      move_done = 1'b0; bn = 1'b0;
      step();
    end
    check("lim_hit", limit_hit, 1);
    be = 1'b1;
    step(); step();
    check("lim_block_req",  move_req, 0);
    check("lim_block_busy", busy,     0);
    clr = 1'b1;
    step();
    clr = 1'b0; be = 1'b0;
    check("lim_clr_limit", limit_hit, 0);
    check("lim_clr_req",   move_req,  0);
    check("lim_clr_busy",  busy,      0);
    check("lim_clr_inc",   count_inc, 0);
`endif

    // Single east press, done two cycles after transfer.
    base = n_inc;
    be = 1'b1; move_ready = 1'b1;
    step();
    check("e_req",  move_req, 1);
    check("e_dir",  move_dir, 2'b01);
    check("e_busy", busy,     1);
    step();
    check("e_xfer_req",  move_req, 0);
    check("e_xfer_busy", busy,     1);
    move_ready = 1'b0;
    step();
    check("e_wait_inc", count_inc, 0);
    move_done = 1'b1;
    step();
    check("e_inc", count_inc, 1);
    move_done = 1'b0;
    step();
    check("e_inc_pulse", count_inc, 0);
    check("e_rel_busy",  busy,      1);
    step();
    check("e_rel_busy2", busy, 1);
    be = 1'b0;
    step();
    check("e_idle_busy", busy, 0);
    check("e_inc_total", n_inc - base, 1);

    // Priority resolution.
    for (int i = 0; i < 6; i++) begin
      do_clr();
      {bn, be, bs, bw} = pat_btn[i];
      step();
      check("prio_req", move_req, 1);
      check("prio_dir", move_dir, pat_dir[i]);
    end
    do_clr();

    // S+W with ready held low; direction must ignore later button changes.
    base = n_inc;
    bs = 1'b1; bw = 1'b1;
    step();
    check("sw_req1", move_req, 1);
    check("sw_dir1", move_dir, 2'b10);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) bn = 1'b1;
      step();
      check("sw_req_hold", move_req, 1);
      check("sw_dir_hold", move_dir, 2'b10);
    end
    move_ready = 1'b1;
    step();
    check("sw_xfer_req", move_req, 0);
    check("sw_xfer_dir", move_dir, 2'b10);
    move_ready = 1'b0; move_done = 1'b1;
    step();
    check("sw_inc", count_inc, 1);
    move_done = 1'b0;
    {bn, be, bs, bw} = 4'b0000;
    step();
    check("sw_idle", busy, 0);
    check("sw_inc_total", n_inc - base, 1);

    // Held button, datapath always ready/done: one move per press.
    base = n_inc;
    bn = 1'b1; move_ready = 1'b1; move_done = 1'b1;
    for (int i = 0; i < 50; i++) step();
    check("hold_inc_total", n_inc - base, 1);
    check("hold_req",  move_req, 0);
    check("hold_busy", busy,     1);
    bn = 1'b0;
    step();
    check("hold_idle", busy, 0);
    bn = 1'b1;
    step(); step(); step();
    bn = 1'b0;
    step();
    check("repress_inc_total", n_inc - base, 2);
    check("repress_idle", busy, 0);
    move_ready = 1'b0; move_done = 1'b0;

    // Abort in REQ by game_over; presses blocked while game_over.
    do_clr();
    base = n_inc;
    bn = 1'b1;
    step();
    check("go_req", move_req, 1);
    game_over = 1'b1;
    step();
    check("go_abort_req",  move_req, 0);
    check("go_abort_busy", busy,     1);
    bn = 1'b0;
    step();
    check("go_abort_idle", busy, 0);
    bs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("go_block_req",  move_req, 0);
      check("go_block_busy", busy,     0);
    end
    check("go_no_inc", n_inc - base, 0);
    game_over = 1'b0;
    step();
    check("go_req2", move_req, 1);
    game_over = 1'b1; move_ready = 1'b1;
    step();
    check("go_xfer_wins_req",  move_req, 0);
    check("go_xfer_wins_busy", busy,     1);
    move_ready = 1'b0; move_done = 1'b1;
    step();
    check("go_wait_inc", count_inc, 1);
    move_done = 1'b0; bs = 1'b0; game_over = 1'b0;
    step();
    check("go_idle", busy, 0);

    // clr in the middle of a handshake.
    be = 1'b1;
    step();
    check("mid_req", move_req, 1);
    clr = 1'b1;
    step();
    check("mid_clr_req",  move_req, 0);
    check("mid_clr_busy", busy,     0);
    check("mid_clr_dir",  move_dir, 0);
    check("mid_clr_inc",  count_inc, 0);
    clr = 1'b0; be = 1'b0;

    // Timeout after 8 wait cycles.
    base = n_inc;
    bw = 1'b1; move_ready = 1'b1;
    step();
    check("to_dir", move_dir, 2'b11);
    step();
    move_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("to_pre_terr", timeout_err, 0);
    end
    step();
    check("to_terr", timeout_err, 1);
    check("to_inc",  count_inc,   0);
    check("to_busy", busy,        1);
    bw = 1'b0;
    step();
    check("to_idle",        busy,        0);
    check("to_terr_sticky", timeout_err, 1);
    check("to_no_inc",      n_inc - base, 0);

    // move_done on the expiry edge counts as done.
    bw = 1'b1; move_ready = 1'b1;
    step(); step();
    move_ready = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    move_done = 1'b1;
    step();
    check("edge_done_inc", count_inc, 1);
    move_done = 1'b0; bw = 1'b0;
    step();
    check("edge_terr_still", timeout_err, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_terr", timeout_err, 0);
    check("clr_busy", busy,        0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter DONE_TIMEOUT, default 1023, sets the maximum cycles spent waiting for move_done before abort.
REQ-002 Parameter MAX_MOVES, default 9999, sets the accepted-move cap; it is used only when MOVE_LIMIT_EN is defined.
REQ-003 Port clk, input, width 1: the single system clock; all logic is on its rising edge.
REQ-004 Port clr, input, width 1: synchronous, active-high reset.
REQ-005 Port game_over, input, width 1: level; high blocks new moves.
REQ-006 Ports bn, be, bs, bw, inputs, width 1 each: already-synchronized, level-held direction buttons (N/E/S/W).
REQ-007 Port move_ready, input, width 1: datapath can accept a move.
REQ-008 Port move_done, input, width 1: one-cycle pulse; the datapath has finished applying the accepted move.
REQ-009 Port move_req, output, width 1: move request to the datapath.
REQ-010 Port move_dir, output, width 2: move direction, encoded 00=N, 01=E, 10=S, 11=W.
REQ-011 Port count_inc, output, width 1: one-cycle pulse per completed move, driving the move counter.
REQ-012 Port busy, output, width 1: high in any state other than IDLE.
REQ-013 Port timeout_err, output, width 1: sticky; high after any move_done timeout.
REQ-014 Port limit_hit, output, width 1: move cap reached; tied to 0 without MOVE_LIMIT_EN.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, WAIT_DONE, RELEASE; all outputs are registered.
REQ-016 IDLE: if game_over=0 and any button is high at edge k, the FSM latches the direction and enters REQ; move_req is high from edge k onward, one cycle of latency.
REQ-017 Simultaneous presses SHALL resolve by fixed priority N > E > S > W (bn+bs -> 00; be+bw -> 01).
REQ-018 move_dir SHALL hold constant from entry to REQ until the next return to IDLE; button changes after latching are ignored.
REQ-019 REQ: move_req stays high until sampled with move_ready=1; that edge is the transfer, and the FSM enters WAIT_DONE with move_req low.
REQ-020 REQ with game_over=1 and move_ready=0 SHALL abort: go to RELEASE, drop move_req, and issue no count_inc; if move_ready=1 on the same edge, the transfer wins.
REQ-021 WAIT_DONE: a 10-bit-min cycle timer starts at 0 on entry; move_done=1 -> count_inc high for exactly the next cycle, then RELEASE.
REQ-022 When the timer reaches DONE_TIMEOUT without move_done, the block SHALL set timeout_err, go to RELEASE, and issue no count_inc; move_done on the same edge as expiry counts as done.
REQ-023 game_over in WAIT_DONE SHALL be ignored; the in-flight move completes.
REQ-024 RELEASE: the FSM stays until bn|be|bs|bw=0 on a sampled edge, then returns to IDLE, so each press yields at most one move.
REQ-025 move_done or move_ready outside their handling states SHALL be ignored.

Reset
REQ-026 clr=1 at an edge SHALL override all other inputs: state IDLE, timer 0, move count 0; move_req, move_dir, count_inc, busy, timeout_err and limit_hit all 0.
REQ-027 clr mid-handshake SHALL abort silently: no count_inc, and no move_req on the following cycle.

Configuration
REQ-028 Macro MOVE_LIMIT_EN defined: a 14-bit count of completed moves; at count == MAX_MOVES, limit_hit=1 and IDLE accepts no presses, as if game_over were high; count saturates; only clr clears.
REQ-029 MOVE_LIMIT_EN undefined: no move counter logic; limit_hit is constant 0; behaviour is otherwise identical.

Structure
REQ-030 Package move_ctrl_pkg SHALL hold the state enum (IDLE/REQ/WAIT_DONE/RELEASE), the dir enum (DIR_N..DIR_W), and the timer/count width constants.
REQ-031 One sub-module, move_timer, SHALL implement the WAIT_DONE timeout counter (clr, start, expired); the priority encoder stays inline.

Verification
REQ-032 Press be only, move_ready=1 -> move_req=1, dir=01 for one cycle; move_done two cycles later -> exactly one count_inc pulse; RELEASE until be=0.
REQ-033 bs and bw pressed together, move_ready held 0 for 5 cycles -> move_req high 5 cycles with dir=10; transfer on cycle 6.
REQ-034 Button held 50 cycles, done returned each time -> exactly one count_inc; release and repress -> a second count_inc.
REQ-035 DONE_TIMEOUT=8, move_done never returned -> timeout_err=1 at wait cycle 8, no count_inc; timeout_err stays high until clr.
REQ-036 game_over asserted in REQ with move_ready=0 -> move_req low next cycle, no count_inc; presses in IDLE while game_over=1 -> move_req stays 0.
REQ-037 With MOVE_LIMIT_EN and MAX_MOVES=3: three moves complete -> limit_hit=1 and a fourth press is ignored; then clr -> limit_hit=0 and all outputs 0.
